uart_tx_port: RTL and testbench

Memory-mapped UART transmitter that answers CPU bus writes to the console address (0xF010) and serializes each byte onto a single 8N1 line. It sits on the CPU address/data bus beside `Memory`, decodes its own two-byte register window, buffers bytes in a small FIFO, and exposes a readable status byte so firmware can poll before writing.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_fifo.sv | 46 ++++
 rtl/uart_tx_port.sv | 154 +++++++++++++++
 tb/tb_uart_tx_port.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
package uart_pkg;

    // Register offsets relative to the block base address
    localparam int UART_DATA_OFS   = 0;
    localparam int UART_STATUS_OFS = 1;

    // Status byte bit positions
    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_EMPTY_BIT = 2;
    localparam int STAT_OVF_BIT   = 7;

    // Transmitter FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with first-word fall-through read data.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; a simultaneous push and pop leaves the occupancy unchanged
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage array; contents need no reset because the pointers gate visibility
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter: register decode, overflow flag,
// baud counter and transmit FSM around a small TX FIFO.
//
//   state    | meaning
//   ---------+------------------------------------------------------
//   ST_IDLE  | line high, waiting for a byte in the FIFO
//   ST_START | start bit (low) for CLKS_PER_BIT cycles
//   ST_DATA  | 8 data bits, LSB first, CLKS_PER_BIT cycles each
//   ST_STOP  | stop bit (high); chains straight into the next frame
module uart_tx_port
    import uart_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR    = 16'hF010,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic        write_en,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        tx,
    output logic        busy
);
    localparam int              BW          = $clog2(CLKS_PER_BIT);
    localparam logic [15:0]     DATA_ADDR   = BASE_ADDR + 16'(UART_DATA_OFS);
    localparam logic [15:0]     STATUS_ADDR = BASE_ADDR + 16'(UART_STATUS_OFS);
    localparam logic [BW-1:0]   BAUD_LAST   = BW'(CLKS_PER_BIT - 1);

    tx_state_t     state, state_next;
    logic [BW-1:0] baud_cnt, baud_next;
    logic [2:0]    bit_cnt, bit_next;
    logic [7:0]    shift, shift_next;
    logic          baud_done;
    logic          tx_next, busy_next;

    logic          data_wr, status_wr, status_rd;
    logic          push, pop;
    logic          fifo_full, fifo_empty;
    logic [7:0]    fifo_data;
    logic          overflow;
    logic [7:0]    status;

    assign data_wr   = write_en && (address == DATA_ADDR);
    assign status_wr = write_en && (address == STATUS_ADDR);
    assign status_rd = !write_en && (address == STATUS_ADDR);
    assign push      = data_wr && !fifo_full;
    assign baud_done = (baud_cnt == BAUD_LAST);

    uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (data_in),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Sticky overflow: set by a data write into a full FIFO, cleared by a status write
    always_ff @(posedge clock) begin
        if (reset)                       overflow <= 1'b0;
        else if (data_wr && fifo_full)   overflow <= 1'b1;
        else if (status_wr)              overflow <= 1'b0;
    end

    // Next-state logic; the baud counter restarts on every state entry
    always_comb begin
        state_next = state;
        baud_next  = baud_done ? '0 : baud_cnt + 1'b1;
        bit_next   = bit_cnt;
        shift_next = shift;
        pop        = 1'b0;
        case (state)
            ST_IDLE: begin
                baud_next = '0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_data;
                    bit_next   = '0;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (baud_done) state_next = ST_DATA;
            end
            ST_DATA: begin
                if (baud_done) begin
                    shift_next = {1'b0, shift[7:1]};
                    bit_next   = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (baud_done) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shift_next = fifo_data;
                        bit_next   = '0;
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        case (state_next)
            ST_START: tx_next = 1'b0;
            ST_DATA:  tx_next = shift_next[0];
            default:  tx_next = 1'b1;
        endcase

        // When heading to IDLE nothing was popped, so the FIFO is non-empty
        // afterwards exactly when it already was or a byte is being pushed
        busy_next = (state_next != ST_IDLE) || push || !fifo_empty;
    end

    // FSM state and registered line/busy outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_cnt  <= bit_next;
            shift    <= shift_next;
            tx       <= tx_next;
            busy     <= busy_next;
        end
    end

    // Status byte assembly and read mux; reads have no side effects
    always_comb begin
        status                 = '0;
        status[STAT_BUSY_BIT]  = busy;
        status[STAT_FULL_BIT]  = fifo_full;
        status[STAT_EMPTY_BIT] = fifo_empty;
        status[STAT_OVF_BIT]   = overflow;
        data_out               = status_rd ? status : 8'h00;
    end

endmodule

// File: tb/tb_uart_tx_port.sv
// Self-checking bench for uart_tx_port: directed vector table, hand-written
// frame/burst/reset sequences, and randomized bus traffic against a
// frame-level reference model.
module tb_uart_tx_port;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam logic [15:0] BASE  = 16'hF010;
    localparam logic [15:0] STAT  = 16'hF011;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] address = 16'h0000;
    logic        write_en = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic [7:0]  data_out;
    logic        tx;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    uart_tx_port #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .address  (address),
        .write_en (write_en),
        .data_in  (data_in),
        .data_out (data_out),
        .tx       (tx),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Reference model: queue of pending bytes plus the position inside the
    // frame currently on the line (0 .. 10*CPB-1).
    logic [7:0] q[$];
    bit         m_ovf = 1'b0;
    bit         m_act = 1'b0;
    int         m_pos = 0;
    logic [7:0] m_byte = 8'h00;

    function automatic logic model_tx();
        int slot;
        if (!m_act) return 1'b1;
        slot = m_pos / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return m_byte[3'(slot - 1)];
        return 1'b1;
    endfunction

    function automatic logic model_busy();
        return m_act || (q.size() != 0);
    endfunction

    function automatic logic [7:0] model_dout(input logic [15:0] a, input logic we);
        logic [7:0] s;
        s = 8'h00;
        if (we || a != STAT) return s;
        s[0] = model_busy();
        s[1] = (q.size() == DEPTH);
        s[2] = (q.size() == 0);
        s[7] = m_ovf;
        return s;
    endfunction

    task automatic model_edge(input logic rst, input logic [15:0] a, input logic we,
                              input logic [7:0] d);
        int pre;
        bit do_pop;
        bit do_push;
        pre     = q.size();
        do_pop  = 1'b0;
        do_push = 1'b0;
        if (rst) begin
            q.delete();
            m_ovf = 1'b0;
            m_act = 1'b0;
            m_pos = 0;
            return;
        end
        if (m_act) begin
            if (m_pos == 10*CPB - 1) begin
                if (pre > 0) do_pop = 1'b1;
                else         m_act  = 1'b0;
                m_pos = 0;
            end else begin
                m_pos++;
            end
        end else if (pre > 0) begin
            do_pop = 1'b1;
        end
        if (we && a == BASE) begin
            if (pre == DEPTH) m_ovf = 1'b1;
            else              do_push = 1'b1;
        end
        if (we && a == STAT) m_ovf = 1'b0;
        if (do_pop) begin
            m_byte = q.pop_front();
            m_act  = 1'b1;
            m_pos  = 0;
        end
        if (do_push) q.push_back(d);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare
    task automatic step(input logic rst, input logic [15:0] a, input logic we,
                        input logic [7:0] d);
        reset    = rst;
        address  = a;
        write_en = we;
        data_in  = d;
        @(posedge clock);
        model_edge(rst, a, we, d);
        #1;
        cyc++;
        check("model_tx", {31'b0, tx}, {31'b0, model_tx()});
        check("model_busy", {31'b0, busy}, {31'b0, model_busy()});
        check("model_dout", {24'b0, data_out}, {24'b0, model_dout(a, we)});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        step(1'b1, 16'h0000, 1'b0, 8'h00);
        step(1'b1, 16'h0000, 1'b0, 8'h00);
    endtask

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  din;
        logic [7:0]  exp_dout;
        logic        exp_tx;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int         n0;
        int         fall;
        logic [7:0] v;
        logic       exp_bit;
        int         r;

        vecs[0] = '{16'hF011, 1'b0, 8'h00, 8'h04, 1'b1, 1'b0};
        vecs[1] = '{16'hF012, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{16'hF00F, 1'b1, 8'hAA, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{16'hF020, 1'b1, 8'h55, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{16'hF010, 1'b0, 8'h33, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{16'hF011, 1'b0, 8'h00, 8'h04, 1'b1, 1'b0};
        vecs[6] = '{16'hF011, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{16'hF00F, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[8] = '{16'hF011, 1'b0, 8'h00, 8'h04, 1'b1, 1'b0};

        // Reset values and decode isolation
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(1'b0, vecs[i].addr, vecs[i].we, vecs[i].din);
            check($sformatf("vec%0d_dout", i), {24'b0, data_out}, {24'b0, vecs[i].exp_dout});
            check($sformatf("vec%0d_tx", i), {31'b0, tx}, {31'b0, vecs[i].exp_tx});
            check($sformatf("vec%0d_busy", i), {31'b0, busy}, {31'b0, vecs[i].exp_busy});
        end

        // Single frame of 0x55 written at edge N
        do_reset();
        v = 8'h55;
        step(1'b0, BASE, 1'b1, v);
        check("single_busy_N", {31'b0, busy}, 32'd1);
        check("single_tx_N", {31'b0, tx}, 32'd1);
        for (int k = 1; k <= 41; k++) begin
            step(1'b0, 16'h0000, 1'b0, 8'h00);
            if (k <= 4)       exp_bit = 1'b0;
            else if (k <= 36) exp_bit = v[3'((k - 5) / 4)];
            else              exp_bit = 1'b1;
            check($sformatf("single_tx_N+%0d", k), {31'b0, tx}, {31'b0, exp_bit});
            check($sformatf("single_busy_N+%0d", k), {31'b0, busy}, {31'b0, (k <= 40)});
        end

        // Burst of six writes: one in flight, four buffered, one dropped
        do_reset();
        step(1'b0, BASE, 1'b1, 8'h41);
        n0 = cyc;
        for (int i = 1; i < 6; i++) step(1'b0, BASE, 1'b1, 8'(8'h41 + i));
        step(1'b0, STAT, 1'b0, 8'h00);
        check("burst_status", {24'b0, data_out}, 32'h83);
        step(1'b0, STAT, 1'b1, 8'h5A);
        step(1'b0, STAT, 1'b0, 8'h00);
        check("ovf_clear_status", {24'b0, data_out}, 32'h03);
        fall = -1;
        for (int i = 0; i < 400 && fall < 0; i++) begin
            step(1'b0, 16'h0000, 1'b0, 8'h00);
            if (!busy) fall = cyc;
        end
        check("burst_busy_fall_cycle", fall, n0 + 201);

        // Reset during DATA bit 3 with two bytes queued
        do_reset();
        step(1'b0, BASE, 1'b1, 8'h11);
        step(1'b0, BASE, 1'b1, 8'h22);
        step(1'b0, BASE, 1'b1, 8'h33);
        idle(15);
        step(1'b1, STAT, 1'b0, 8'h00);
        check("midreset_tx", {31'b0, tx}, 32'd1);
        check("midreset_status", {24'b0, data_out}, 32'h04);
        r = 0;
        for (int i = 0; i < 60; i++) begin
            step(1'b0, 16'h0000, 1'b0, 8'h00);
            if (tx !== 1'b1 || busy !== 1'b0) r++;
        end
        check("midreset_quiet_line", r, 0);

        // Randomized bus traffic against the model
        do_reset();
        for (int i = 0; i < 2500; i++) begin
            r = $urandom_range(0, 999);
            if (r < 2)        step(1'b1, 16'h0000, 1'b0, 8'h00);
            else if (r < 40)  step(1'b0, BASE, 1'b1, 8'($urandom));
            else if (r < 50)  step(1'b0, STAT, 1'b1, 8'($urandom));
            else if (r < 200) step(1'b0, STAT, 1'b0, 8'h00);
            else              step(1'b0, 16'($urandom), 1'($urandom), 8'($urandom));
        end
        idle(250);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
